ttl74194: RTL and testbench

4-bit bidirectional universal shift register: synchronous parallel load, shift right, shift left and hold, with an asynchronous clear. Sits directly upstream of the dual 4:1 multiplexer stage. `q[1:0]` drives that mux's 2-bit select, so the register can step or rotate the mux through its four inputs (one-hot/ring sequencing, loadable start point). `q[3:2]` serve as cascade or general outputs.

---
 rtl/ttl74194.sv | 38 +++
 tb/tb_ttl74194.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ttl74194.sv
// 4-bit bidirectional universal shift register: hold, shift right, shift left, parallel load,
// with an asynchronous active-high clear. q[1:0] feeds the downstream 4:1 mux select.
module ttl74194 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       ser_right,
  input  logic       ser_left,
  input  logic [3:0] data,
  output logic [3:0] q
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    case (mode)
      2'b00:   q_d = q_q;
      2'b01:   q_d = {q_q[2:0], ser_right};
      2'b10:   q_d = {ser_left, q_q[3:1]};
      2'b11:   q_d = data;
      // Only reachable with X/Z on mode; poison the register so undriven controls show up.
      default: q_d = 4'bxxxx;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q <= 4'b0000;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_ttl74194.sv
// Directed bench for ttl74194: expected register values are queued as each step is driven
// and popped for comparison one edge later.
module tb_ttl74194;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic       ser_right_drv;
  logic       ser_left;
  logic [3:0] data;
  logic [3:0] q;
  logic       ring_en;
  logic       ser_right;

  int unsigned n_compared = 0;
  int unsigned n_mismatched = 0;

  typedef struct {
    string      tag;
    logic [3:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];

  // External ring tie: ser_right follows q[3] when enabled.
  assign ser_right = ring_en ? q[3] : ser_right_drv;

  ttl74194 dut (
    .clock     (clock),
    .reset     (reset),
    .mode      (mode),
    .ser_right (ser_right),
    .ser_left  (ser_left),
    .data      (data),
    .q         (q)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_compared++;
    assert (obs === exp)
    else begin
      n_mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of controls at the falling edge, queue the expectation,
  // then compare just after the rising edge that samples them.
  task automatic step(input string tag, input logic [1:0] m, input logic [3:0] d,
                      input logic sr, input logic sl, input logic [3:0] exp);
    sb_entry_t e;
    @(negedge clock);
    mode          = m;
    data          = d;
    ser_right_drv = sr;
    ser_left      = sl;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, q, 4'bxxxx);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, q, e.exp);
    end
  endtask

  logic [3:0] ring_exp [4];
  logic [1:0] sel_exp  [4];

  initial begin
    reset         = 1'b1;
    mode          = 2'b00;
    data          = 4'b0000;
    ser_right_drv = 1'b0;
    ser_left      = 1'b0;
    ring_en       = 1'b0;
    ring_exp      = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    sel_exp       = '{2'b10, 2'b00, 2'b00, 2'b01};

    #2;
    check("reset_init", q, 4'b0000);
    @(negedge clock);
    reset = 1'b0;

    // Asynchronous clear from 1010, then reset holds against a load.
    step("pre_reset_load", 2'b11, 4'b1010, 1'b0, 1'b0, 4'b1010);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("reset_async", q, 4'b0000);
    step("reset_hold_0", 2'b11, 4'b1111, 1'b0, 1'b0, 4'b0000);
    step("reset_hold_1", 2'b11, 4'b1111, 1'b0, 1'b0, 4'b0000);
    @(negedge clock);
    reset = 1'b0;

    // Load then hold.
    step("load_0110", 2'b11, 4'b0110, 1'b0, 1'b0, 4'b0110);
    for (int i = 0; i < 3; i++) step("hold", 2'b00, 4'b1001, 1'b1, 1'b1, 4'b0110);

    // Shift right: walk a one out, then fill with ones.
    step("load_0001", 2'b11, 4'b0001, 1'b0, 1'b0, 4'b0001);
    step("sr0_a", 2'b01, 4'b1111, 1'b0, 1'b1, 4'b0010);
    step("sr0_b", 2'b01, 4'b1111, 1'b0, 1'b1, 4'b0100);
    step("sr0_c", 2'b01, 4'b1111, 1'b0, 1'b1, 4'b1000);
    step("sr0_d", 2'b01, 4'b1111, 1'b0, 1'b1, 4'b0000);
    step("sr1_a", 2'b01, 4'b0000, 1'b1, 1'b0, 4'b0001);
    step("sr1_b", 2'b01, 4'b0000, 1'b1, 1'b0, 4'b0011);
    step("sr1_c", 2'b01, 4'b0000, 1'b1, 1'b0, 4'b0111);
    step("sr1_d", 2'b01, 4'b0000, 1'b1, 1'b0, 4'b1111);

    // Shift left: walk a one out, then fill with ones.
    step("load_1000", 2'b11, 4'b1000, 1'b0, 1'b0, 4'b1000);
    step("sl0_a", 2'b10, 4'b1111, 1'b1, 1'b0, 4'b0100);
    step("sl0_b", 2'b10, 4'b1111, 1'b1, 1'b0, 4'b0010);
    step("sl0_c", 2'b10, 4'b1111, 1'b1, 1'b0, 4'b0001);
    step("sl0_d", 2'b10, 4'b1111, 1'b1, 1'b0, 4'b0000);
    step("sl1_a", 2'b10, 4'b0000, 1'b0, 1'b1, 4'b1000);
    step("sl1_b", 2'b10, 4'b0000, 1'b0, 1'b1, 4'b1100);
    step("sl1_c", 2'b10, 4'b0000, 1'b0, 1'b1, 4'b1110);
    step("sl1_d", 2'b10, 4'b0000, 1'b0, 1'b1, 4'b1111);

    // Ring through the mux select with ser_right tied to q[3].
    step("ring_load", 2'b11, 4'b0001, 1'b0, 1'b0, 4'b0001);
    ring_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("ring", 2'b01, 4'b0000, 1'b0, 1'b0, ring_exp[i]);
      check("mux_sel", {2'b00, q[1:0]}, {2'b00, sel_exp[i]});
    end
    step("ring_again_a", 2'b01, 4'b0000, 1'b0, 1'b0, 4'b0010);
    step("ring_again_b", 2'b01, 4'b0000, 1'b0, 1'b0, 4'b0100);

    // Mid-sequence reset pulse between edges, then a load from cleared state.
    #1;
    reset = 1'b1;
    #1;
    check("reset_mid", q, 4'b0000);
    #1;
    reset = 1'b0;
    ring_en = 1'b0;
    step("post_reset_load", 2'b11, 4'b1001, 1'b0, 1'b0, 4'b1001);
    check("post_reset_sel", {2'b00, q[1:0]}, 4'b0001);

    if (sb_q.size() != 0) check("sb_drain", 4'(sb_q.size()), 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
